// File: rtl/jtframe_spi_upload.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_spi_upload
// Purpose  : SPI mode-0 slave transmitter for the core->ARM upload path
//            (NVRAM / hiscore). After the ARM sends the UPLOAD_CMD byte,
//            game memory is streamed out on SPI_DO one byte per 8 SCKs,
//            starting at address 0. SPI inputs are oversampled in clk.
// Ports    : clk, rst_n          - system clock, async active-low reset
//            spi_sck/ss/di       - SPI inputs from the ARM (asynchronous)
//            spi_do, spi_do_oe   - SPI data out (MSB first) and its enable
//            ioctl_addr/rd/din   - memory read port (din valid DIN_LAT clks
//                                  after the rd strobe)
//            upload              - high while an upload session is active
//            chksum              - mod-256 sum of the bytes sent
// Options  : JTFRAME_UPLOAD_CHKSUM_EN enables the checksum accumulator;
//            without it chksum is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_spi_upload #(
  parameter int         AW         = 16,
  parameter logic [7:0] UPLOAD_CMD = 8'h54,
  parameter int         DIN_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_sck,
  input  logic          spi_ss,
  input  logic          spi_di,
  output logic          spi_do,
  output logic          spi_do_oe,
  output logic [AW-1:0] ioctl_addr,
  output logic          ioctl_rd,
  input  logic [7:0]    ioctl_din,
  output logic          upload,
  output logic [7:0]    chksum
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_XFER   = 2'd2,
    ST_IGNORE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Synchronisers; sck carries one extra stage for edge detection
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [1:0] ss_sync_q, ss_sync_d;
  logic [1:0] di_sync_q, di_sync_d;

  logic [2:0]    bit_cnt_q, bit_cnt_d;    // rising edges within a byte
  logic [6:0]    cmd_sh_q, cmd_sh_d;      // first 7 command bits
  logic [6:0]    shift_q, shift_d;        // remaining output bits
  logic [3:0]    fall_cnt_q, fall_cnt_d;  // falls of the byte on DO (0..8)
  logic          ld_pend_q, ld_pend_d;    // next fall loads the shadow byte
  logic [7:0]    shadow_q, shadow_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          do_q, do_d;
  logic          oe_q, oe_d;
  logic          upload_q, upload_d;
  logic [DIN_LAT-1:0] rd_pipe_q, rd_pipe_d;

  logic sck_rise, sck_fall, ss_hi, di_s;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign ss_hi    = ss_sync_q[1];
  assign di_s     = di_sync_q[1];

  // Delay line marking the cycle in which ioctl_din carries the read data
  generate
    if (DIN_LAT == 1) begin : g_lat1
      assign rd_pipe_d = rd_q;
    end else begin : g_lat2
      assign rd_pipe_d = {rd_pipe_q[DIN_LAT-2:0], rd_q};
    end
  endgenerate

  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], spi_sck};
    ss_sync_d  = {ss_sync_q[0], spi_ss};
    di_sync_d  = {di_sync_q[0], spi_di};

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_sh_d   = cmd_sh_q;
    shift_d    = shift_q;
    fall_cnt_d = fall_cnt_q;
    ld_pend_d  = ld_pend_q;
    addr_d     = addr_q;
    rd_d       = 1'b0;
    do_d       = do_q;
    oe_d       = oe_q;
    upload_d   = upload_q;
    shadow_d   = rd_pipe_q[DIN_LAT-1] ? ioctl_din : shadow_q;

    if (ss_hi) begin
      // Deselect wins over any SCK edge seen in the same cycle
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      fall_cnt_d = 4'd0;
      ld_pend_d  = 1'b0;
      oe_d       = 1'b0;
      upload_d   = 1'b0;
      do_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
        ST_CMD: begin
          if (sck_rise) begin
            cmd_sh_d  = {cmd_sh_q[5:0], di_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if ({cmd_sh_q, di_s} == UPLOAD_CMD) begin
                state_d    = ST_XFER;
                addr_d     = '0;
                rd_d       = 1'b1;
                upload_d   = 1'b1;
                oe_d       = 1'b1;
                ld_pend_d  = 1'b1;
                fall_cnt_d = 4'd0;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_XFER: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              // Last bit sampled by the ARM: fetch the following byte
              addr_d    = addr_q + {{(AW-1){1'b0}}, 1'b1};
              rd_d      = 1'b1;
              ld_pend_d = 1'b1;
            end
          end
          if (sck_fall) begin
            if (ld_pend_q) begin
              shift_d    = shadow_q[6:0];
              do_d       = shadow_q[7];
              fall_cnt_d = 4'd1;
              ld_pend_d  = 1'b0;
            end else if (fall_cnt_q != 4'd0 && fall_cnt_q < 4'd8) begin
              shift_d    = {shift_q[5:0], 1'b0};
              do_d       = shift_q[6];
              fall_cnt_d = fall_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          // ST_IGNORE: silent until deselect
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= 3'b000;
      ss_sync_q  <= 2'b11;
      di_sync_q  <= 2'b00;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      cmd_sh_q   <= 7'd0;
      shift_q    <= 7'd0;
      fall_cnt_q <= 4'd0;
      ld_pend_q  <= 1'b0;
      shadow_q   <= 8'd0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      do_q       <= 1'b0;
      oe_q       <= 1'b0;
      upload_q   <= 1'b0;
      rd_pipe_q  <= '0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ss_sync_q  <= ss_sync_d;
      di_sync_q  <= di_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_sh_q   <= cmd_sh_d;
      shift_q    <= shift_d;
      fall_cnt_q <= fall_cnt_d;
      ld_pend_q  <= ld_pend_d;
      shadow_q   <= shadow_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      do_q       <= do_d;
      oe_q       <= oe_d;
      upload_q   <= upload_d;
      rd_pipe_q  <= rd_pipe_d;
    end
  end

`ifdef JTFRAME_UPLOAD_CHKSUM_EN
  // A byte counts once its 8th fall has put its last bit on DO
  logic [7:0] chksum_q, chksum_d;
  logic [7:0] byte_q, byte_d;
  logic       xfer_entry, byte_load, byte_done;

  assign xfer_entry = (state_q != ST_XFER) && (state_d == ST_XFER);
  assign byte_load  = !ss_hi && (state_q == ST_XFER) && sck_fall && ld_pend_q;
  assign byte_done  = !ss_hi && (state_q == ST_XFER) && sck_fall && !ld_pend_q &&
                      (fall_cnt_q == 4'd7);

  always_comb begin
    byte_d   = byte_load ? shadow_q : byte_q;
    chksum_d = chksum_q;
    if (xfer_entry) begin
      chksum_d = 8'd0;
    end else if (byte_done) begin
      chksum_d = chksum_q + byte_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chksum_q <= 8'd0;
      byte_q   <= 8'd0;
    end else begin
      chksum_q <= chksum_d;
      byte_q   <= byte_d;
    end
  end

  assign chksum = chksum_q;
`else
  assign chksum = 8'd0;
`endif

  assign spi_do     = do_q;
  assign spi_do_oe  = oe_q;
  assign ioctl_addr = addr_q;
  assign ioctl_rd   = rd_q;
  assign upload     = upload_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_spi_upload.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_spi_upload
// Purpose  : Self-checking bench for jtframe_spi_upload. Two instances
//            (AW=16 and AW=4) share the SPI bus, each with its own memory.
//            Expected bytes, addresses and checksums come from the memory
//            contents and the session rules, not from the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_spi_upload;

  localparam int HALF = 83;   // SCK half period in ns (clk period 10 ns)
`ifdef JTFRAME_UPLOAD_CHKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_ss = 1'b1;
  logic        spi_di = 1'b0;

  logic        spi_do, spi_do_oe, ioctl_rd, upload;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_din = 8'd0;
  logic [7:0]  chksum;

  logic        spi_do4, oe4, rd4, upload4;
  logic [3:0]  addr4;
  logic [7:0]  din4 = 8'd0;
  logic [7:0]  chk4;

  logic [7:0]  mem  [65536];
  logic [7:0]  mem4 [16];
  logic [7:0]  rx16 [64];
  logic [7:0]  rx4  [64];

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0, rd_cnt4 = 0;
  logic oe_seen = 1'b0, up_seen = 1'b0, rd_in_rst = 1'b0;
  int addr_log [$];
  int addr_log4 [$];

  always #5 clk = ~clk;

  jtframe_spi_upload #(.AW(16), .UPLOAD_CMD(8'h54), .DIN_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_di(spi_di),
    .spi_do(spi_do), .spi_do_oe(spi_do_oe), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din), .upload(upload), .chksum(chksum)
  );

  jtframe_spi_upload #(.AW(4), .UPLOAD_CMD(8'h54), .DIN_LAT(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_di(spi_di),
    .spi_do(spi_do4), .spi_do_oe(oe4), .ioctl_addr(addr4),
    .ioctl_rd(rd4), .ioctl_din(din4), .upload(upload4), .chksum(chk4)
  );

  // Synchronous memories with one cycle read latency
  always @(posedge clk) begin
    if (ioctl_rd) ioctl_din <= mem[ioctl_addr];
    if (rd4)      din4      <= mem4[addr4];
  end

  always @(negedge clk) begin
    if (ioctl_rd) begin rd_cnt++;  addr_log.push_back(int'(ioctl_addr)); end
    if (rd4)      begin rd_cnt4++; addr_log4.push_back(int'(addr4)); end
    if (spi_do_oe || oe4) oe_seen = 1'b1;
    if (upload || upload4) up_seen = 1'b1;
    if (!rst_n && (ioctl_rd || rd4)) rd_in_rst = 1'b1;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_mon();
    rd_cnt = 0; rd_cnt4 = 0;
    oe_seen = 1'b0; up_seen = 1'b0;
    addr_log.delete(); addr_log4.delete();
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] r16, output logic [7:0] r4);
    r16 = 8'd0; r4 = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      spi_di = tx[7-i];
      #HALF;
      spi_sck = 1'b1;
      r16[7-i] = spi_do;
      r4[7-i]  = spi_do4;
      #HALF;
      spi_sck = 1'b0;
    end
  endtask

  task automatic ss_end();
    #HALF;
    spi_ss = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // One session: command byte followed by n data bytes
  task automatic xfer(input logic [7:0] cmd, input int n);
    logic [7:0] a, b;
    clear_mon();
    spi_ss = 1'b0;
    #HALF;
    spi_bits(cmd, 8, a, b);
    for (int k = 0; k < n; k++) begin
      spi_bits(8'($urandom), 8, a, b);
      rx16[k] = a;
      rx4[k]  = b;
    end
    ss_end();
  endtask

  task automatic fill_mem(input int n);
    for (int k = 0; k < n; k++) mem[k] = 8'($urandom);
    for (int k = 0; k < 16; k++) mem4[k] = 8'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({spi_do, spi_do_oe, ioctl_rd, upload} !== 4'b0000 || ioctl_addr !== 16'd0 ||
        chksum !== 8'd0) begin
      errors++;
      $display("FAIL reset16: do/oe/rd/up=%b addr=%h chk=%h required 0000/0/0",
               {spi_do, spi_do_oe, ioctl_rd, upload}, ioctl_addr, chksum);
    end
    checks++;
    if ({spi_do4, oe4, rd4, upload4} !== 4'b0000 || addr4 !== 4'd0 || chk4 !== 8'd0) begin
      errors++;
      $display("FAIL reset4: do/oe/rd/up=%b addr=%h chk=%h required 0000/0/0",
               {spi_do4, oe4, rd4, upload4}, addr4, chk4);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] pat [3];
    logic [7:0] sum;
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin pat[0] = 8'h80; pat[1] = 8'h80; pat[2] = 8'h01; end
      sum = 8'd0;
      for (int k = 0; k < 3; k++) begin
        mem[k] = pat[k]; mem4[k] = pat[k]; sum = sum + pat[k];
      end
      xfer(8'h54, 3);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rx16[k] !== pat[k] || rx4[k] !== pat[k]) begin
          errors++;
          $display("FAIL basic_byte%0d: got %h/%h required %h", k, rx16[k], rx4[k], pat[k]);
        end
      end
      checks++;
      if (ioctl_addr !== 16'd3 || addr4 !== 4'd3) begin
        errors++;
        $display("FAIL basic_addr: got %0d/%0d required 3", ioctl_addr, addr4);
      end
      checks++;
      if (rd_cnt != 4 || addr_log.size() != 4 || addr_log[0] != 0 || addr_log[3] != 3) begin
        errors++;
        $display("FAIL basic_reads: count %0d required 4", rd_cnt);
      end
      checks++;
      if (!up_seen || !oe_seen || upload !== 1'b0 || spi_do_oe !== 1'b0) begin
        errors++;
        $display("FAIL basic_session_flags: seen up/oe=%b%b now up/oe=%b%b required 11/00",
                 up_seen, oe_seen, upload, spi_do_oe);
      end
      checks++;
      if (chksum !== (CHK_ON ? sum : 8'd0) || chk4 !== (CHK_ON ? sum : 8'd0)) begin
        errors++;
        $display("FAIL basic_chksum: got %h/%h required %h", chksum, chk4,
                 CHK_ON ? sum : 8'd0);
      end
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] s16, s4;
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(1, 24));
      fill_mem(64);
      xfer(8'h54, n);
      s16 = 8'd0; s4 = 8'd0;
      for (int k = 0; k < n; k++) begin
        s16 = s16 + mem[k];
        s4  = s4 + mem4[k % 16];
        checks++;
        if (rx16[k] !== mem[k] || rx4[k] !== mem4[k % 16]) begin
          errors++;
          $display("FAIL rand_byte%0d: got %h/%h required %h/%h", k, rx16[k], rx4[k],
                   mem[k], mem4[k % 16]);
        end
      end
      checks++;
      if (int'(ioctl_addr) != n || int'(addr4) != n % 16 || rd_cnt != n + 1) begin
        errors++;
        $display("FAIL rand_addr: got %0d/%0d reads %0d required %0d/%0d reads %0d",
                 ioctl_addr, addr4, rd_cnt, n, n % 16, n + 1);
      end
      checks++;
      if (chksum !== (CHK_ON ? s16 : 8'd0) || chk4 !== (CHK_ON ? s4 : 8'd0)) begin
        errors++;
        $display("FAIL rand_chksum: got %h/%h required %h/%h", chksum, chk4,
                 CHK_ON ? s16 : 8'd0, CHK_ON ? s4 : 8'd0);
      end
    end
  endtask

  task automatic test_wrap();
    fill_mem(64);
    xfer(8'h54, 18);
    checks++;
    if (addr_log4.size() < 18) begin
      errors++;
      $display("FAIL wrap_reads: got %0d reads required at least 18", addr_log4.size());
    end else begin
      for (int k = 0; k < 18; k++) begin
        if (addr_log4[k] != k % 16) begin
          errors++;
          $display("FAIL wrap_addr%0d: got %0d required %0d", k, addr_log4[k], k % 16);
        end
      end
    end
    for (int k = 14; k < 18; k++) begin
      checks++;
      if (rx4[k] !== mem4[k % 16]) begin
        errors++;
        $display("FAIL wrap_byte%0d: got %h required %h", k, rx4[k], mem4[k % 16]);
      end
    end
    checks++;
    if (addr4 !== 4'd2 || ioctl_addr !== 16'd18) begin
      errors++;
      $display("FAIL wrap_end_addr: got %0d/%0d required 2/18", addr4, ioctl_addr);
    end
  endtask

  task automatic test_ignore();
    logic [7:0] cmd;
    logic [15:0] a16;
    logic [3:0] a4;
    for (int it = 0; it < 2; it++) begin
      cmd = (it == 0) ? 8'h12 : 8'($urandom);
      if (cmd == 8'h54) cmd = 8'h55;
      a16 = ioctl_addr; a4 = addr4;
      xfer(cmd, 2);
      checks++;
      if (oe_seen || up_seen || rd_cnt != 0 || rd_cnt4 != 0) begin
        errors++;
        $display("FAIL ignore_%h: oe_seen=%b up_seen=%b reads=%0d/%0d required 0/0/0/0",
                 cmd, oe_seen, up_seen, rd_cnt, rd_cnt4);
      end
      checks++;
      if (ioctl_addr !== a16 || addr4 !== a4) begin
        errors++;
        $display("FAIL ignore_addr_hold: got %h/%h required %h/%h", ioctl_addr, addr4, a16, a4);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] a, b;
    fill_mem(64);
    clear_mon();
    spi_ss = 1'b0;
    #HALF;
    spi_bits(8'h54, 8, a, b);
    spi_bits(8'h00, 8, a, b);
    rx16[0] = a;
    spi_bits(8'h00, 4, a, b);
    #(HALF / 2);
    #2 spi_ss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (spi_do_oe !== 1'b0 || oe4 !== 1'b0 || upload !== 1'b0) begin
      errors++;
      $display("FAIL abort_oe: oe=%b/%b upload=%b required 0", spi_do_oe, oe4, upload);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rx16[0] !== mem[0] || rd_cnt != 2 || ioctl_addr !== 16'd1) begin
      errors++;
      $display("FAIL abort_first: byte %h reads %0d addr %0d required %h 2 1",
               rx16[0], rd_cnt, ioctl_addr, mem[0]);
    end
    checks++;
    if (chksum !== (CHK_ON ? mem[0] : 8'd0)) begin
      errors++;
      $display("FAIL abort_chksum: got %h required %h", chksum, CHK_ON ? mem[0] : 8'd0);
    end
    xfer(8'h54, 2);
    checks++;
    if (addr_log.size() == 0 || addr_log[0] != 0 || rx16[0] !== mem[0] ||
        rx16[1] !== mem[1]) begin
      errors++;
      $display("FAIL abort_restart: bytes %h %h required %h %h", rx16[0], rx16[1],
               mem[0], mem[1]);
    end
  endtask

  task automatic test_reset_mid_xfer();
    logic [7:0] a, b;
    fill_mem(64);
    clear_mon();
    spi_ss = 1'b0;
    #HALF;
    spi_bits(8'h54, 8, a, b);
    spi_bits(8'h00, 8, a, b);
    spi_bits(8'h00, 3, a, b);
    @(negedge clk);
    rd_in_rst = 1'b0;
    rst_n = 1'b0;
    spi_ss = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_do, spi_do_oe, ioctl_rd, upload} !== 4'b0000 || ioctl_addr !== 16'd0 ||
        chksum !== 8'd0 || rd_in_rst) begin
      errors++;
      $display("FAIL rst_mid: do/oe/rd/up=%b addr=%h chk=%h rd_in_rst=%b required 0",
               {spi_do, spi_do_oe, ioctl_rd, upload}, ioctl_addr, chksum, rd_in_rst);
    end
    rst_n = 1'b1;
    clear_mon();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (rd_cnt != 0 || oe_seen || up_seen || ioctl_addr !== 16'd0) begin
      errors++;
      $display("FAIL rst_after: reads %0d oe %b up %b addr %h required 0",
               rd_cnt, oe_seen, up_seen, ioctl_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_wrap();
    test_ignore();
    test_abort();
    test_reset_mid_xfer();
    test_basic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
